cache_way_ctrl: RTL and testbench

- Miss/replacement controller for the 4-way set-associative write-back, write-allocate cache.
- Per set it keeps tree pseudo-LRU state. It picks a victim way and sequences the write-back and line-fill bursts to memory.
- It drives one-hot way enables into the tag/data/valid/dirty arrays. It is the sequencing owner of the way-select decode.

---
 rtl/cache_way_ctrl_if.sv | 46 ++++
 rtl/cache_way_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cache_way_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cache_way_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_way_ctrl_if
// Purpose  : CPU, array-control and memory-burst signals of the 4-way
//            miss/replacement controller, grouped as one bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_way_ctrl_if #(
  parameter int IDX_W = 6,
  parameter int BEATS = 4
);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic             req;
  logic             wr;
  logic [IDX_W-1:0] set_idx;
  logic [3:0]       hit_way;
  logic [3:0]       valid_vec;
  logic [3:0]       dirty_vec;
  logic             mem_req;
  logic             mem_wr;
  logic             mem_ack;
  logic [BW-1:0]    beat;
  logic [3:0]       way_en;
  logic             data_we;
  logic             tag_we;
  logic             dirty_set;
  logic             dirty_clr;
  logic             ready;
  logic             done;

  // Environment side: CPU, tag/data arrays and memory.
  modport master (
    output req, wr, set_idx, hit_way, valid_vec, dirty_vec, mem_ack,
    input  mem_req, mem_wr, beat, way_en, data_we, tag_we,
           dirty_set, dirty_clr, ready, done
  );

  // Controller side.
  modport slave (
    input  req, wr, set_idx, hit_way, valid_vec, dirty_vec, mem_ack,
    output mem_req, mem_wr, beat, way_en, data_we, tag_we,
           dirty_set, dirty_clr, ready, done
  );
endinterface
`default_nettype wire

// File: rtl/cache_way_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_way_ctrl
// Purpose  : Tree-PLRU victim selection and write-back / line-fill burst
//            sequencing for a 4-way write-back, write-allocate cache.
// Revision : 1.0 - initial release
// ============================================================================
module cache_way_ctrl #(
  parameter int IDX_W = 6,
  parameter int BEATS = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  cache_way_ctrl_if.slave bus
);
  localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SETS = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [1:0]       victim_q, victim_d;
  logic             wr_q, wr_d;
  logic [IDX_W-1:0] set_q, set_d;
  logic [2:0]       plru_q [SETS];
  logic             plru_we;
  logic [1:0]       plru_way;

  logic [1:0] hit_idx;
  logic [1:0] miss_victim;
  logic       last_beat;

  function automatic logic [1:0] lowest_one(input logic [3:0] v);
    if      (v[0]) return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Bit 0 chooses the pair, bit 1 / bit 2 choose within pair {0,1} / {2,3}.
  function automatic logic [1:0] plru_pick(input logic [2:0] b);
    return b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
  endfunction

  function automatic logic [2:0] plru_next(input logic [2:0] b, input logic [1:0] way);
    logic [2:0] n;
    n = b;
    case (way)
      2'd0:    begin n[0] = 1'b1; n[1] = 1'b1; end
      2'd1:    begin n[0] = 1'b1; n[1] = 1'b0; end
      2'd2:    begin n[0] = 1'b0; n[2] = 1'b1; end
      default: begin n[0] = 1'b0; n[2] = 1'b0; end
    endcase
    return n;
  endfunction

  assign hit_idx     = lowest_one(bus.hit_way);
  assign miss_victim = (~bus.valid_vec != 4'b0000) ? lowest_one(~bus.valid_vec)
                                                    : plru_pick(plru_q[set_q]);
  assign last_beat   = (beat_q == BW'(BEATS - 1));
  assign bus.beat    = beat_q;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    victim_d      = victim_q;
    wr_d          = wr_q;
    set_d         = set_q;
    plru_we       = 1'b0;
    plru_way      = victim_q;
    bus.mem_req   = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.way_en    = 4'b0000;
    bus.data_we   = 1'b0;
    bus.tag_we    = 1'b0;
    bus.dirty_set = 1'b0;
    bus.dirty_clr = 1'b0;
    bus.ready     = 1'b0;
    bus.done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.req) begin
          set_d   = bus.set_idx;
          wr_d    = bus.wr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (bus.hit_way != 4'b0000) begin
          bus.way_en    = 4'b0001 << hit_idx;
          bus.data_we   = wr_q;
          bus.dirty_set = wr_q;
          bus.done      = 1'b1;
          plru_we       = 1'b1;
          plru_way      = hit_idx;
          state_d       = S_IDLE;
        end else begin
          victim_d = miss_victim;
          beat_d   = '0;
          state_d  = (bus.valid_vec[miss_victim] && bus.dirty_vec[miss_victim]) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        bus.mem_req = 1'b1;
        bus.mem_wr  = 1'b1;
        bus.way_en  = 4'b0001 << victim_q;
        if (bus.mem_ack) begin
          if (last_beat) begin
            bus.dirty_clr = 1'b1;
            beat_d        = '0;
            state_d       = S_FILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_FILL: begin
        bus.mem_req = 1'b1;
        bus.way_en  = 4'b0001 << victim_q;
        if (bus.mem_ack) begin
          bus.data_we = 1'b1;
          if (last_beat) begin
            bus.tag_we = 1'b1;
            beat_d     = '0;
            state_d    = S_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        bus.way_en    = 4'b0001 << victim_q;
        bus.data_we   = wr_q;
        bus.dirty_set = wr_q;
        bus.done      = 1'b1;
        plru_we       = 1'b1;
        plru_way      = victim_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      victim_q <= 2'd0;
      wr_q     <= 1'b0;
      set_q    <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= 3'b000;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      wr_q     <= wr_d;
      set_q    <= set_d;
      if (plru_we) plru_q[set_q] <= plru_next(plru_q[set_q], plru_way);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cache_way_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_way_ctrl
// Purpose  : Directed self-checking bench for the cache miss/replacement
//            controller (hits, fills, write-backs, stalls, PLRU, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_way_ctrl;
  localparam int IDX_W = 6;
  localparam int BEATS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cache_way_ctrl_if #(.IDX_W(IDX_W), .BEATS(BEATS)) bus ();

  cache_way_ctrl #(.IDX_W(IDX_W), .BEATS(BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE; returns in the LOOKUP cycle with array results applied.
  task automatic issue(input logic w, input logic [IDX_W-1:0] s, input logic [3:0] hit,
                       input logic [3:0] valid, input logic [3:0] dirty);
    bus.req = 1'b1; bus.wr = w; bus.set_idx = s;
    tick();
    bus.req = 1'b0; bus.hit_way = hit; bus.valid_vec = valid; bus.dirty_vec = dirty;
    #1;
    chk("lookup_ready", bus.ready, 1'b0);
  endtask

  task automatic burst(input logic is_wb, input logic [3:0] exp_way, input int stall);
    for (int i = 0; i < BEATS; i++) begin
      for (int k = 0; k < stall; k++) begin
        bus.mem_ack = 1'b0; bus.req = 1'b1;
        #1;
        chk("stall_beat", bus.beat, i);
        chk("stall_mem_req", bus.mem_req, 1'b1);
        chk("stall_data_we", bus.data_we, 1'b0);
        tick();
      end
      bus.req = 1'b0; bus.mem_ack = 1'b1;
      #1;
      chk("burst_mem_req", bus.mem_req, 1'b1);
      chk("burst_mem_wr", bus.mem_wr, is_wb);
      chk("burst_way_en", bus.way_en, exp_way);
      chk("burst_beat", bus.beat, i);
      chk("burst_data_we", bus.data_we, !is_wb);
      chk("burst_tag_we", bus.tag_we, (!is_wb && i == BEATS - 1));
      chk("burst_dirty_clr", bus.dirty_clr, (is_wb && i == BEATS - 1));
      tick();
    end
    bus.mem_ack = 1'b0;
  endtask

  // Call in the DONE cycle; also checks the return to IDLE.
  task automatic finish_access(input logic [3:0] exp_way, input logic w);
    #1;
    chk("done_pulse", bus.done, 1'b1);
    chk("done_way_en", bus.way_en, exp_way);
    chk("done_data_we", bus.data_we, w);
    chk("done_dirty_set", bus.dirty_set, w);
    chk("done_mem_req", bus.mem_req, 1'b0);
    tick();
    chk("idle_ready", bus.ready, 1'b1);
    chk("idle_done", bus.done, 1'b0);
    chk("idle_way_en", bus.way_en, 4'b0000);
  endtask

  initial begin
    bus.req = 1'b0; bus.wr = 1'b0; bus.set_idx = '0; bus.hit_way = 4'b0000;
    bus.valid_vec = 4'b0000; bus.dirty_vec = 4'b0000; bus.mem_ack = 1'b0;

    repeat (2) tick();
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_way_en", bus.way_en, 4'b0000);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_beat", bus.beat, 0);
    chk("rst_done", bus.done, 1'b0);
    rst = 1'b1;
    tick();

    // Read miss, set 5, nothing valid: fill way0. PLRU[5] -> b0=1,b1=1.
    issue(1'b0, 6'd5, 4'b0000, 4'b0000, 4'b0000);
    chk("miss_done", bus.done, 1'b0);
    chk("miss_way_en", bus.way_en, 4'b0000);
    tick();
    burst(1'b0, 4'b0001, 0);
    finish_access(4'b0001, 1'b0);

    // Read hit way2 in set 5: done in LOOKUP. PLRU[5] -> b0=0,b1=1,b2=1.
    issue(1'b0, 6'd5, 4'b0100, 4'b1111, 4'b0000);
    chk("hit_done", bus.done, 1'b1);
    chk("hit_way_en", bus.way_en, 4'b0100);
    chk("hit_data_we", bus.data_we, 1'b0);
    tick();
    chk("hit_idle_done", bus.done, 1'b0);

    // Set 5 all valid, clean: PLRU picks way1. Stalled fill with ignored req pulses.
    issue(1'b0, 6'd5, 4'b0000, 4'b1111, 4'b0000);
    tick();
    burst(1'b0, 4'b0010, 3);
    finish_access(4'b0010, 1'b0);

    // PLRU[5] now b0=1,b2=1: next all-valid miss picks way3.
    issue(1'b0, 6'd5, 4'b0000, 4'b1111, 4'b0000);
    tick();
    burst(1'b0, 4'b1000, 0);
    finish_access(4'b1000, 1'b0);

    // Write miss set 7, all valid and dirty, PLRU=000: write-back way0 then fill.
    issue(1'b1, 6'd7, 4'b0000, 4'b1111, 4'b1111);
    tick();
    burst(1'b1, 4'b0001, 0);
    burst(1'b0, 4'b0001, 0);
    finish_access(4'b0001, 1'b1);

    // PLRU[7] now b0=1,b2=0: victim way2; reset lands mid write-back at beat 2.
    issue(1'b1, 6'd7, 4'b0000, 4'b1111, 4'b1111);
    tick();
    bus.mem_ack = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("wb_mid_beat", bus.beat, 2);
    chk("wb_mid_way_en", bus.way_en, 4'b0100);
    rst = 1'b0;
    #1;
    chk("arst_mem_req", bus.mem_req, 1'b0);
    chk("arst_beat", bus.beat, 0);
    chk("arst_ready", bus.ready, 1'b1);
    chk("arst_way_en", bus.way_en, 4'b0000);
    tick();
    rst = 1'b1;
    tick();

    // PLRU cleared by reset: all-valid clean miss in set 7 picks way0 again.
    issue(1'b0, 6'd7, 4'b0000, 4'b1111, 4'b0000);
    tick();
    burst(1'b0, 4'b0001, 0);
    finish_access(4'b0001, 1'b0);

    // Multi-hot hit: lowest set bit wins, single done pulse.
    issue(1'b1, 6'd3, 4'b1010, 4'b1111, 4'b0000);
    chk("mhit_way_en", bus.way_en, 4'b0010);
    chk("mhit_done", bus.done, 1'b1);
    chk("mhit_data_we", bus.data_we, 1'b1);
    chk("mhit_dirty_set", bus.dirty_set, 1'b1);
    tick();
    chk("mhit_done_once", bus.done, 1'b0);
    chk("mhit_ready", bus.ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
